// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Write-side front end of the register file. Buffers register write-back
//   requests in a DEPTH-entry FIFO and drains them in arrival order into the
//   register-file write port, one per cycle, whenever the port is not stalled.
//
// Configuration macro: WB_BYPASS_EN
//   defined   - rd_hit/rd_data report the youngest pending entry for rd_addr
//   undefined - rd_hit and rd_data are tied to 0 and no comparators are built
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   write request handshake (in_ready = !full)
//   in_addr, in_data    destination register index and write data
//   rf_stall            register-file write port busy this cycle
//   rf_we/rf_waddr/
//   rf_wdata            write port driven from the head entry
//   rd_addr             bypass lookup index
//   rd_hit, rd_data     bypass result
//   count, empty        occupancy
module regfile_wb_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_hit,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              full;
  logic              push;
  logic              pop;

  // Full is taken from the occupancy counter, never from pointer equality.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !rst;
  assign pop      = !empty && !rf_stall && !rst;

  assign rf_we    = pop;
  assign rf_waddr = mem_addr[rd_ptr];
  assign rf_wdata = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage is not reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Walk entries oldest to youngest; a later match overrides, so the
  // youngest pending write for rd_addr wins. The head counts even while
  // it is being written this cycle.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (mem_addr[idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = mem_data[idx];
      end
    end
    if (rst) begin
      rd_hit  = 1'b0;
      rd_data = '0;
    end
  end
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign rd_hit         = 1'b0;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model. Expected register
// writes go into a scoreboard queue; a separate monitor pops and compares
// whenever the DUT asserts rf_we.
module tb_regfile_wb_queue;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr = '0;
  logic [DATA_W-1:0]     in_data = '0;
  logic                  rf_stall = 1'b0;
  logic                  rf_we;
  logic [ADDR_W-1:0]     rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [ADDR_W-1:0]     rd_addr = '0;
  logic                  rd_hit;
  logic [DATA_W-1:0]     rd_data;
  logic [$clog2(DEPTH):0] count;
  logic                  empty;

  always #5 clk = ~clk;

  regfile_wb_queue #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr (in_addr),
    .in_data (in_data),
    .rf_stall(rf_stall),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .rd_addr (rd_addr),
    .rd_hit  (rd_hit),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t pend[$];   // reference model: pending writes, oldest first
  wr_t expq[$];   // scoreboard: writes the register file should see next
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check the cycle's outputs against the
  // model, then advance the model across the coming posedge.
  task automatic step(input bit v, input int a, input int d, input bit st,
                      input int ra, input bit r);
    bit  full_m;
    bit  acc;
    bit  popm;
    bit  hit;
    int  hd;
    wr_t w;
    @(negedge clk);
    in_valid = v;
    in_addr  = ADDR_W'(a);
    in_data  = DATA_W'(d);
    rf_stall = st;
    rd_addr  = ADDR_W'(ra);
    rst      = r;
    #1;
    full_m = (pend.size() == DEPTH);
    acc    = v && !full_m && !r;
    popm   = (pend.size() != 0) && !st && !r;
    hit    = 1'b0;
    hd     = 0;
    if (!r) begin
      foreach (pend[i]) begin
        if (pend[i].a == ADDR_W'(ra)) begin
          hit = 1'b1;
          hd  = int'(pend[i].d);
        end
      end
    end
    chk("count", int'(count), pend.size());
    chk("empty", int'(empty), int'(pend.size() == 0));
    chk("in_ready", int'(in_ready), int'(!full_m));
    chk("rf_we", int'(rf_we), int'(popm));
`ifdef WB_BYPASS_EN
    chk("rd_hit", int'(rd_hit), int'(hit));
    if (hit) chk("rd_data", int'(rd_data), hd);
`else
    chk("rd_hit", int'(rd_hit), 0);
    chk("rd_data", int'(rd_data), 0);
`endif
    if (popm) begin
      expq.push_back(pend[0]);
      void'(pend.pop_front());
    end
    if (acc) begin
      w.a = ADDR_W'(a);
      w.d = DATA_W'(d);
      pend.push_back(w);
    end
    if (r) pend.delete();
  endtask

  // Monitor: every write presented to the register file must match the
  // oldest outstanding expected write.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rf_we === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write at %0t",
                   rf_waddr, rf_wdata, $time);
        end else begin
          mon_e = expq.pop_front();
          chk("wb_addr", int'(rf_waddr), int'(mon_e.a));
          chk("wb_data", int'(rf_wdata), int'(mon_e.d));
        end
      end
    end
  end

  initial begin
    // reset
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // single write, one-cycle latency
    step(1, 3, 'hA5, 0, 3, 0);
    step(0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 3, 0);

    // fill under stall, 5th request ignored, release drains in order
    for (int i = 0; i < 4; i++) step(1, i, 'h30 + i, 1, i, 0);
    step(1, 7, 'h99, 1, 7, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);

    // duplicate address: youngest pending data wins
    step(1, 2, 'h11, 1, 2, 0);
    step(1, 2, 'h22, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 2, 0);

    // continuous enqueue+dequeue, pointers wrap
    for (int i = 0; i < 11; i++) step(1, i % 8, 'h40 + i, 0, i % 8, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // reset mid-operation drops pending writes
    for (int i = 0; i < 3; i++) step(1, 4 + i, 'h60 + i, 1, 5, 0);
    step(0, 0, 0, 0, 5, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5, 0);

    // full with no stall: dequeue only, enqueue accepted next cycle
    for (int i = 0; i < 4; i++) step(1, i + 1, 'h70 + i, 1, 1, 0);
    step(1, 5, 'h55, 0, 5, 0);
    step(1, 5, 'h55, 0, 5, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 5, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)), ($urandom_range(0, 9) < 3),
           int'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0);

    #5;
    chk("leftover_expected_writes", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
